// File: rtl/commit_mem_read_rbuffer_if.sv
// Bus bundle between the commit-stage read controller / load lookup and the read-return buffer.
// master drives beats, clears and queries; slave (the buffer) returns hit data and line status.
interface commit_mem_read_rbuffer_if #(
   parameter int LINE_WORDS = 8
);
   logic                  i_uncached_en;
   logic [31:0]           i_uncached_addr;
   logic [31:0]           i_uncached_data;
   logic                  i_uncached_pop;
   logic                  i_cached_en;
   logic [31:0]           i_cached_addr;
   logic [31:0]           i_cached_data;
   logic                  i_cached_clear;
   logic                  i_flush;
   logic                  i_query_en;
   logic [31:0]           i_query_addr;
   logic                  i_query_uncached;
   logic                  o_query_hit;
   logic [31:0]           o_query_data;
   logic [LINE_WORDS-1:0] o_line_valid;
   logic [31:0]           o_line_addr;
   logic                  o_line_complete;
   logic                  o_busy;

   modport master (
      output i_uncached_en, i_uncached_addr, i_uncached_data, i_uncached_pop,
      output i_cached_en, i_cached_addr, i_cached_data, i_cached_clear,
      output i_flush, i_query_en, i_query_addr, i_query_uncached,
      input  o_query_hit, o_query_data, o_line_valid, o_line_addr, o_line_complete, o_busy
   );

   modport slave (
      input  i_uncached_en, i_uncached_addr, i_uncached_data, i_uncached_pop,
      input  i_cached_en, i_cached_addr, i_cached_data, i_cached_clear,
      input  i_flush, i_query_en, i_query_addr, i_query_uncached,
      output o_query_hit, o_query_data, o_line_valid, o_line_addr, o_line_complete, o_busy
   );
endinterface

// File: rtl/commit_mem_read_rbuffer.sv
// Read-return buffer: one refill line collected word-by-word plus one uncached result slot,
// with a zero-cycle lookup so loads can be served before the dcache data array is rewritten.
module commit_mem_read_rbuffer #(
   parameter int LINE_WORDS = 8,
   parameter bit BYPASS_EN  = 1'b1
) (
   input  logic                  clk,
   input  logic                  resetn,
   commit_mem_read_rbuffer_if.slave bus
);
   localparam int          IDXW      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam logic [31:0] LINE_MASK = ~(32'(4 * LINE_WORDS) - 32'd1);

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FILLING  = 2'd1,
      COMPLETE = 2'd2
   } line_state_t;

   line_state_t           state_reg;
   logic [LINE_WORDS-1:0] valid_reg;
   logic [31:0]           line_addr_reg;
   logic [31:0]           line_mem [LINE_WORDS];
   logic                  unc_valid_reg;
   logic [31:0]           unc_addr_reg;
   logic [31:0]           unc_data_reg;

   logic [IDXW-1:0]       c_idx;
   logic [IDXW-1:0]       q_idx;
   logic [LINE_WORDS-1:0] c_onehot;
   logic [LINE_WORDS-1:0] fill_mask;
   logic                  c_accept;
   logic                  c_same_line;
   logic                  q_hit;
   logic [31:0]           q_data;

   assign c_idx       = IDXW'((bus.i_cached_addr >> 2) & 32'(LINE_WORDS - 1));
   assign q_idx       = IDXW'((bus.i_query_addr >> 2) & 32'(LINE_WORDS - 1));
   // A beat is written unless the line is being dropped or is already complete.
   assign c_accept    = bus.i_cached_en && !bus.i_cached_clear && (state_reg != COMPLETE);
   assign c_same_line = (bus.i_cached_addr & LINE_MASK) == line_addr_reg;
   assign fill_mask   = valid_reg | c_onehot;

   generate
      for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_onehot
         assign c_onehot[gi] = (c_idx == IDXW'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg     <= EMPTY;
         valid_reg     <= '0;
         line_addr_reg <= '0;
      end else if (bus.i_cached_clear) begin
         state_reg <= EMPTY;
         valid_reg <= '0;
      end else if (c_accept) begin
         if (state_reg == FILLING && c_same_line) begin
            valid_reg <= fill_mask;
            if (&fill_mask) begin
               state_reg <= COMPLETE;
            end
         end else begin
            // First beat of a line, or a different-tag beat that restarts the line.
            line_addr_reg <= bus.i_cached_addr & LINE_MASK;
            valid_reg     <= c_onehot;
            state_reg     <= (&c_onehot) ? COMPLETE : FILLING;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (c_accept) begin
         line_mem[c_idx] <= bus.i_cached_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         unc_valid_reg <= 1'b0;
         unc_addr_reg  <= '0;
         unc_data_reg  <= '0;
      end else if (bus.i_uncached_en) begin
         unc_valid_reg <= 1'b1;
         unc_addr_reg  <= bus.i_uncached_addr;
         unc_data_reg  <= bus.i_uncached_data;
      end else if (bus.i_uncached_pop || bus.i_flush) begin
         unc_valid_reg <= 1'b0;
      end
   end

   // Same-cycle beats take priority over stored contents since they overwrite them at the edge.
   always_comb begin
      q_hit  = 1'b0;
      q_data = '0;
      if (bus.i_query_en) begin
         if (bus.i_query_uncached) begin
            if (BYPASS_EN && bus.i_uncached_en &&
                bus.i_uncached_addr[31:2] == bus.i_query_addr[31:2]) begin
               q_hit  = 1'b1;
               q_data = bus.i_uncached_data;
            end else if (unc_valid_reg && unc_addr_reg[31:2] == bus.i_query_addr[31:2]) begin
               q_hit  = 1'b1;
               q_data = unc_data_reg;
            end
         end else begin
            if (BYPASS_EN && c_accept &&
                bus.i_cached_addr[31:2] == bus.i_query_addr[31:2]) begin
               q_hit  = 1'b1;
               q_data = bus.i_cached_data;
            end else if (state_reg != EMPTY &&
                         (bus.i_query_addr & LINE_MASK) == line_addr_reg &&
                         valid_reg[q_idx]) begin
               q_hit  = 1'b1;
               q_data = line_mem[q_idx];
            end
         end
      end
   end

   assign bus.o_query_hit     = q_hit;
   assign bus.o_query_data    = q_data;
   assign bus.o_line_valid    = valid_reg;
   assign bus.o_line_addr     = line_addr_reg;
   assign bus.o_line_complete = (state_reg == COMPLETE);
   assign bus.o_busy          = (state_reg != EMPTY) || unc_valid_reg;
endmodule

// File: tb/tb_commit_mem_read_rbuffer.sv
// Randomised plus directed bench for the read-return buffer; one instance with forwarding and one
// without share the stimulus, and a monitor checks both against a line/slot reference model.
module tb_commit_mem_read_rbuffer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   logic        uen, upop, cen, cclr, flush, qen, qunc;
   logic [31:0] ua, ud, ca, cd, qa;

   commit_mem_read_rbuffer_if #(.LINE_WORDS(8)) bus_b ();
   commit_mem_read_rbuffer_if #(.LINE_WORDS(8)) bus_n ();

   assign bus_b.i_uncached_en    = uen;   assign bus_n.i_uncached_en    = uen;
   assign bus_b.i_uncached_addr  = ua;    assign bus_n.i_uncached_addr  = ua;
   assign bus_b.i_uncached_data  = ud;    assign bus_n.i_uncached_data  = ud;
   assign bus_b.i_uncached_pop   = upop;  assign bus_n.i_uncached_pop   = upop;
   assign bus_b.i_cached_en      = cen;   assign bus_n.i_cached_en      = cen;
   assign bus_b.i_cached_addr    = ca;    assign bus_n.i_cached_addr    = ca;
   assign bus_b.i_cached_data    = cd;    assign bus_n.i_cached_data    = cd;
   assign bus_b.i_cached_clear   = cclr;  assign bus_n.i_cached_clear   = cclr;
   assign bus_b.i_flush          = flush; assign bus_n.i_flush          = flush;
   assign bus_b.i_query_en       = qen;   assign bus_n.i_query_en       = qen;
   assign bus_b.i_query_addr     = qa;    assign bus_n.i_query_addr     = qa;
   assign bus_b.i_query_uncached = qunc;  assign bus_n.i_query_uncached = qunc;

   commit_mem_read_rbuffer #(.LINE_WORDS(8), .BYPASS_EN(1'b1)) dut_b (
      .clk(clk), .resetn(resetn), .bus(bus_b.slave)
   );
   commit_mem_read_rbuffer #(.LINE_WORDS(8), .BYPASS_EN(1'b0)) dut_n (
      .clk(clk), .resetn(resetn), .bus(bus_n.slave)
   );

   typedef struct {
      logic        qen;
      logic        qunc;
      logic [31:0] qa;
      logic        hit_b;
      logic [31:0] data_b;
      logic        hit_n;
      logic [31:0] data_n;
      logic [7:0]  mask;
      logic        comp;
      logic        busy;
      logic        chk_laddr;
      logic [31:0] laddr;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Reference model: a line is a base address plus per-word valid/data; slot is valid/addr/data.
   bit          m_active;
   logic [31:0] m_base;
   bit   [7:0]  m_valid;
   logic [31:0] m_data [8];
   bit          u_v;
   logic [31:0] u_a, u_d;
   bit          laddr_once;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         if (mon_e.qen) begin
            chk("hit_byp",  32'(bus_b.o_query_hit), 32'(mon_e.hit_b));
            chk("data_byp", bus_b.o_query_data,      mon_e.data_b);
            chk("hit_nob",  32'(bus_n.o_query_hit), 32'(mon_e.hit_n));
            chk("data_nob", bus_n.o_query_data,      mon_e.data_n);
            $display("query addr=%h unc=%0d hit_byp=%0d data_byp=%h hit_nob=%0d data_nob=%h",
                     mon_e.qa, mon_e.qunc, bus_b.o_query_hit, bus_b.o_query_data,
                     bus_n.o_query_hit, bus_n.o_query_data);
         end else begin
            chk("idle_hit", 32'(bus_b.o_query_hit | bus_n.o_query_hit), 32'd0);
            chk("idle_data", bus_b.o_query_data | bus_n.o_query_data, 32'd0);
         end
         chk("mask_byp", 32'(bus_b.o_line_valid), 32'(mon_e.mask));
         chk("mask_nob", 32'(bus_n.o_line_valid), 32'(mon_e.mask));
         chk("complete", 32'({bus_b.o_line_complete, bus_n.o_line_complete}),
             32'({mon_e.comp, mon_e.comp}));
         chk("busy", 32'({bus_b.o_busy, bus_n.o_busy}), 32'({mon_e.busy, mon_e.busy}));
         if (mon_e.chk_laddr) begin
            chk("line_addr_byp", bus_b.o_line_addr, mon_e.laddr);
            chk("line_addr_nob", bus_n.o_line_addr, mon_e.laddr);
         end
      end
   end

   task automatic idle();
      uen = 0; upop = 0; cen = 0; cclr = 0; flush = 0; qen = 0; qunc = 0;
      ua = '0; ud = '0; ca = '0; cd = '0; qa = '0;
   endtask

   // Push the expected response for the current inputs, then advance the model over the edge.
   task automatic step();
      exp_t        e;
      int          qi;
      int          ci;
      bit          full;
      logic        nb_hit, byp;
      logic [31:0] nb_data;
      qi      = int'((qa >> 2) & 32'd7);
      ci      = int'((ca >> 2) & 32'd7);
      full    = m_active && (m_valid == 8'hFF);
      nb_hit  = 1'b0;
      nb_data = '0;
      byp     = 1'b0;
      if (qen) begin
         if (qunc) begin
            nb_hit = u_v && (u_a >> 2) == (qa >> 2);
            byp    = uen && (ua >> 2) == (qa >> 2);
            if (nb_hit) nb_data = u_d;
         end else begin
            nb_hit = m_active && (qa & ~32'h1F) == m_base && m_valid[qi];
            byp    = cen && !cclr && !full && (ca >> 2) == (qa >> 2);
            if (nb_hit) nb_data = m_data[qi];
         end
      end
      e.qen       = qen;
      e.qunc      = qunc;
      e.qa        = qa;
      e.hit_n     = nb_hit;
      e.data_n    = nb_data;
      e.hit_b     = nb_hit || byp;
      e.data_b    = byp ? (qunc ? ud : cd) : nb_data;
      e.mask      = m_valid;
      e.comp      = full;
      e.busy      = m_active || u_v;
      e.chk_laddr = m_active || laddr_once;
      e.laddr     = m_active ? m_base : 32'd0;
      laddr_once  = 1'b0;
      exp_q.push_back(e);

      if (cclr) begin
         m_active = 1'b0;
         m_valid  = '0;
      end else if (cen && !full) begin
         if (!m_active || (ca & ~32'h1F) != m_base) begin
            m_base   = ca & ~32'h1F;
            m_valid  = '0;
            m_active = 1'b1;
         end
         m_valid[ci] = 1'b1;
         m_data[ci]  = cd;
      end
      if (uen) begin
         u_v = 1'b1; u_a = ua; u_d = ud;
      end else if (upop || flush) begin
         u_v = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      resetn   = 1'b0;
      m_active = 0; m_base = '0; m_valid = '0; u_v = 0; u_a = '0; u_d = '0;
      repeat (2) @(posedge clk);
      #1;
      resetn     = 1'b1;
      laddr_once = 1'b1;
      step();

      // Wrap-order refill starting at word 5, with the first-beat address queried twice.
      for (int k = 0; k < 8; k++) begin
         idle();
         cen = 1; ca = 32'h8000_1040 + 32'(((5 + k) % 8) * 4); cd = ca;
         if (k < 2) begin qen = 1; qa = 32'h8000_1054; end
         step();
      end
      idle(); qen = 1; qa = 32'h8000_1048; step();

      // Uncached slot: beat, pop+new beat together, flush; line must survive.
      idle(); uen = 1; ua = 32'hBFD0_0004; ud = 32'h1234_5678;
      qen = 1; qunc = 1; qa = 32'hBFD0_0004; step();
      idle(); upop = 1; uen = 1; ua = 32'hBFD0_0008; ud = 32'hCAFE_F00D;
      qen = 1; qunc = 1; qa = 32'hBFD0_0004; step();
      idle(); qen = 1; qunc = 1; qa = 32'hBFD0_0008; step();
      idle(); flush = 1; step();
      idle(); qen = 1; qunc = 1; qa = 32'hBFD0_0008; step();
      idle(); qen = 1; qa = 32'h8000_1048; step();

      // Clear wins over a same-cycle refill beat.
      idle(); cclr = 1; cen = 1; ca = 32'h8000_1040; cd = 32'h5555_AAAA;
      qen = 1; qa = 32'h8000_1040; step();
      idle(); qen = 1; qa = 32'h8000_1040; step();

      // Different-tag beat while filling restarts the line.
      idle(); cen = 1; ca = 32'h8000_3010; cd = 32'h1111_1111; step();
      idle(); cen = 1; ca = 32'h8000_3020; cd = 32'h2222_2222; step();
      idle(); qen = 1; qa = 32'h8000_3010; step();
      idle(); qen = 1; qa = 32'h8000_3020; step();
      idle(); cclr = 1; step();

      for (int n = 0; n < 400; n++) begin
         idle();
         cen   = ($urandom_range(0, 99) < 45);
         ca    = (($urandom_range(0, 9) == 0) ? 32'h8000_1020 : 32'h8000_1000)
                 + 32'($urandom_range(0, 7) * 4);
         cd    = $urandom;
         cclr  = ($urandom_range(0, 99) < 4);
         uen   = ($urandom_range(0, 99) < 15);
         ua    = 32'hBFD0_0000 + 32'($urandom_range(0, 3) * 4);
         ud    = $urandom;
         upop  = ($urandom_range(0, 99) < 8);
         flush = ($urandom_range(0, 99) < 5);
         qen   = ($urandom_range(0, 99) < 70);
         qunc  = $urandom_range(0, 1) == 1;
         if (qunc)
            qa = 32'hBFD0_0000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
         else
            qa = (($urandom_range(0, 3) == 0) ? 32'h8000_1020 : 32'h8000_1000)
                 + 32'($urandom_range(0, 31));
         step();
      end
      idle();
      step();
      repeat (2) @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
